// File: rtl/config_chain_loader.sv
// Serial configuration-chain loader: takes host words over valid/ready, clears the
// chain, shifts exactly CHAIN_LEN bits into its head and watches the tail for faults.
module config_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              chain_in,
  output logic              chain_shift,
  output logic              chain_reset,
  input  logic              chain_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LEN       = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shifter;
  logic [CNT_W-1:0]  bits_left;   // unshifted bits still held in shifter
  logic [CNT_W-1:0]  loaded;      // chain bits accepted so far
  logic [CNT_W-1:0]  shifted;     // chain bits shifted so far
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  take;
  logic              accept;

  // The final word only contributes what is left of the chain; its upper bits are dropped.
  always_comb begin
    remaining = LEN - loaded;
    take      = (remaining > WORD_BITS) ? WORD_BITS : remaining;
    accept    = word_valid && word_ready;
  end

  // NOTE: every output and next-state term gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    word_ready  = 1'b0;
    chain_shift = 1'b0;
    chain_in    = 1'b0;
    chain_reset = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        chain_reset = 1'b1;
        busy        = 1'b1;
        state_nxt   = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        // Ready while the last held bit is going out, so words follow with no bubble.
        word_ready  = (bits_left <= ONE) && (loaded < LEN);
        chain_shift = (bits_left != '0);
        chain_in    = shifter[0];
        if (chain_shift && (shifted == LEN - ONE)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order within or across blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter   <= '0;
      bits_left <= '0;
      loaded    <= '0;
      shifted   <= '0;
      error     <= 1'b0;
    end else begin
      if (state == S_IDLE && start) error <= 1'b0;
      if (state == S_CLEAR) begin
        shifter   <= '0;
        bits_left <= '0;
        loaded    <= '0;
        shifted   <= '0;
      end
      if (chain_shift) begin
        shifter   <= shifter >> 1;
        bits_left <= bits_left - ONE;
        shifted   <= shifted + ONE;
        // A freshly cleared chain may only present zeros at its tail during the load.
        if (chain_out) error <= 1'b1;
      end
      // A new word overrides the shift of the previous word's final bit in the same cycle.
      if (accept) begin
        shifter   <= word_in;
        bits_left <= take;
        loaded    <= loaded + take;
      end
    end
  end

endmodule
